// File: rtl/mbist_march_ctrl.sv
// March C- MBIST controller: drives memory commands and checks read data two cycles later.
// Optional MBIST_STOP_ON_FAIL_EN aborts to DONE on the first mismatch.
module mbist_march_ctrl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned CAPACITY      = 16,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic [DATA_WIDTH-1:0]    fail_data,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     write_read,
    output logic [ADDR_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]    wdata,
    input  logic [DATA_WIDTH-1:0]    rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]    ADDR_LAST = ADDR_WIDTH'(CAPACITY - 1);
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE   = ERR_CNT_WIDTH'(1);
    localparam logic [2:0]               ELEM_LAST = 3'd5;

    // Element table: E0 up w0, E1 up r0w1, E2 up r1w0, E3 down r0w1, E4 down r1w0, E5 up r0
    function automatic logic elem_up(input logic [2:0] e);
        return (e == 3'd0) || (e == 3'd1) || (e == 3'd2) || (e == 3'd5);
    endfunction

    function automatic logic elem_two_op(input logic [2:0] e);
        return (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem_wbg(input logic [2:0] e);
        logic [DATA_WIDTH-1:0] bg;
        bg = ((e == 3'd1) || (e == 3'd3)) ? '1 : '0;
        return bg;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] elem_rbg(input logic [2:0] e);
        logic [DATA_WIDTH-1:0] bg;
        bg = ((e == 3'd2) || (e == 3'd4)) ? '1 : '0;
        return bg;
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              elem_q, elem_d, elem_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    phase_q, phase_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    drain_q, drain_d;

    logic                    p1_valid, p2_valid;
    logic [ADDR_WIDTH-1:0]   p1_addr, p2_addr;
    logic [DATA_WIDTH-1:0]   p1_exp, p2_exp;

    logic                    fail_q;
    logic [ADDR_WIDTH-1:0]   fail_addr_q;
    logic [DATA_WIDTH-1:0]   fail_data_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    logic two_op, cur_write, op_done, at_last, rd_push, mismatch, launch, abort, active;

    always_comb begin
        two_op    = elem_two_op(elem_q);
        cur_write = two_op ? phase_q : (elem_q != ELEM_LAST);
        op_done   = !two_op || phase_q;
        at_last   = elem_up(elem_q) ? (addr_q == ADDR_LAST) : (addr_q == '0);
        elem_nxt  = elem_q + 3'd1;
        active    = (state_q == S_SETUP) || (state_q == S_RUN) || (state_q == S_DRAIN);
        rd_push   = (state_q == S_RUN) && !cur_write;
        // Case inequality so an undriven/X read word is reported as a mismatch
        mismatch  = p2_valid && (rdata !== p2_exp);
        launch    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
`ifdef MBIST_STOP_ON_FAIL_EN
        abort     = mismatch && active;
`else
        abort     = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        wdata_d = wdata_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETUP;
                    elem_d  = 3'd0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                    wdata_d = elem_wbg(3'd0);
                end
            end
            S_SETUP: begin
                state_d = S_RUN;
                phase_d = 1'b0;
            end
            S_RUN: begin
                if (!op_done) begin
                    phase_d = 1'b1;
                end else if (!at_last) begin
                    phase_d = 1'b0;
                    addr_d  = elem_up(elem_q) ? addr_q + ADDR_ONE : addr_q - ADDR_ONE;
                end else if (elem_q == ELEM_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    state_d = S_SETUP;
                    elem_d  = elem_nxt;
                    addr_d  = elem_up(elem_nxt) ? '0 : ADDR_LAST;
                    phase_d = 1'b0;
                    wdata_d = elem_wbg(elem_nxt);
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_DONE;
                else         drain_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            wdata_q <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            wdata_q <= wdata_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_valid <= 1'b0;
            p1_addr  <= '0;
            p1_exp   <= '0;
            p2_valid <= 1'b0;
            p2_addr  <= '0;
            p2_exp   <= '0;
        end else begin
            p1_valid <= rd_push && !abort;
            p1_addr  <= addr_q;
            p1_exp   <= elem_rbg(elem_q);
            p2_valid <= p1_valid && !abort;
            p2_addr  <= p1_addr;
            p2_exp   <= p1_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            err_cnt_q   <= '0;
        end else if (launch) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            err_cnt_q   <= '0;
        end else if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_ONE;
            if (!fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= p2_addr;
                fail_data_q <= rdata;
            end
        end
    end

    assign busy       = active;
    assign done       = (state_q == S_DONE);
    assign pass       = done && !fail_q;
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign err_cnt    = err_cnt_q;
    assign write_read = (state_q == S_RUN) && cur_write;
    assign address    = addr_q;
    assign wdata      = wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl with a behavioural memory (1-cycle write data lead, 2-cycle read latency).
module tb_mbist_march_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CAP = 16;
    localparam int EW = 6;
`ifdef MBIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, fail, write_read;
    logic [AW-1:0] fail_addr, address;
    logic [DW-1:0] fail_data, wdata, rdata;
    logic [EW-1:0] err_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mbist_march_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CAPACITY(CAP),
        .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .err_cnt(err_cnt),
        .write_read(write_read), .address(address), .wdata(wdata), .rdata(rdata)
    );

    // fault: 0 none, 1 address 5 drops writes and holds 8'hA5, 2 rdata bit0 stuck-at-1, 3 rdata inverted
    int            fault = 0;
    logic [DW-1:0] mem [0:CAP-1];
    logic [DW-1:0] wdata_prev = '0;
    logic [DW-1:0] rd1 = '0;
    logic [DW-1:0] rd2 = '0;

    always @(posedge clk) begin
        wdata_prev <= wdata;
        if (write_read && !(fault == 1 && address == 4'd5)) mem[address] <= wdata_prev;
        rd1 <= mem[address];
        rd2 <= rd1;
    end

    always_comb begin
        rdata = rd2;
        if (fault == 2) rdata = rd2 | 8'h01;
        else if (fault == 3) rdata = ~rd2;
    end

    logic          busy_log [0:511];
    logic          wr_log   [0:511];
    logic [AW-1:0] addr_log [0:511];
    logic [DW-1:0] wd_log   [0:511];

    // Launch a run; returns the cycle index (SETUP = 1) where done is first seen high.
    task automatic run(input bit hold, output int cyc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); if (!hold) start = 1'b0;
        cyc = 1;
        while (1) begin
            busy_log[cyc] = busy;
            wr_log[cyc]   = write_read;
            addr_log[cyc] = address;
            wd_log[cyc]   = wdata;
            if (done || cyc >= 400) break;
            @(negedge clk); cyc++;
        end
        if (!done) $display("FAIL run_timeout: done not seen within %0d cycles", cyc);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, pass, fail, write_read} !== 5'b0)
            $display("FAIL reset_flags got %b exp 00000", {busy, done, pass, fail, write_read});
        else passed++;
        checks++; if ({address, wdata} !== '0)
            $display("FAIL reset_cmd got addr %h wdata %h exp 0 0", address, wdata);
        else passed++;
        checks++; if ({fail_addr, fail_data, err_cnt} !== '0)
            $display("FAIL reset_diag got %h/%h/%h exp 0", fail_addr, fail_data, err_cnt);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_clean_run();
        int cyc, bc;
        fault = 0;
        run(1'b0, cyc);
        checks++; if (cyc !== 169) $display("FAIL clean_done_cycle got %0d exp 169", cyc); else passed++;
        checks++; if ({pass, fail, err_cnt} !== {1'b1, 1'b0, 6'd0})
            $display("FAIL clean_result got pass %b fail %b err %0d exp 1 0 0", pass, fail, err_cnt);
        else passed++;
        bc = 0;
        for (int i = 1; i <= 168; i++) bc += int'(busy_log[i]);
        checks++; if (bc !== 168 || busy_log[169] !== 1'b0)
            $display("FAIL clean_busy got %0d high, final %b exp 168, 0", bc, busy_log[169]);
        else passed++;
        checks++; if ({wr_log[1], wr_log[2], addr_log[2]} !== {1'b0, 1'b1, 4'd0})
            $display("FAIL e0_first_write got %b %b %h exp 0 1 0", wr_log[1], wr_log[2], addr_log[2]);
        else passed++;
        checks++; if (wd_log[18] !== 8'hFF || wd_log[51] !== 8'h00)
            $display("FAIL setup_wdata got %h %h exp ff 00", wd_log[18], wd_log[51]);
        else passed++;
        checks++; if ({wr_log[117], addr_log[117], addr_log[150]} !== {1'b0, 4'd15, 4'd0})
            $display("FAIL setup_addr got %b %h %h exp 0 f 0", wr_log[117], addr_log[117], addr_log[150]);
        else passed++;
        checks++; if ({wr_log[166], addr_log[166], busy_log[167]} !== {1'b0, 4'd15, 1'b1})
            $display("FAIL last_read got %b %h %b exp 0 f 1", wr_log[166], addr_log[166], busy_log[167]);
        else passed++;
    endtask

    task automatic test_addr5_fault();
        int cyc;
        fault = 1;
        mem[5] = 8'hA5;
        run(1'b0, cyc);
        checks++; if (cyc !== (STOP ? 32 : 169))
            $display("FAIL a5_done_cycle got %0d exp %0d", cyc, STOP ? 32 : 169);
        else passed++;
        checks++; if ({pass, fail, fail_addr, fail_data} !== {1'b0, 1'b1, 4'd5, 8'hA5})
            $display("FAIL a5_diag got pass %b fail %b addr %h data %h exp 0 1 5 a5", pass, fail, fail_addr, fail_data);
        else passed++;
        checks++; if (err_cnt !== (STOP ? 6'd1 : 6'd5))
            $display("FAIL a5_err_cnt got %0d exp %0d", err_cnt, STOP ? 1 : 5);
        else passed++;
        checks++; if (write_read !== 1'b0) $display("FAIL a5_done_wr got %b exp 0", write_read); else passed++;
    endtask

    task automatic test_stuck_bit0();
        int cyc;
        fault = 2;
        run(1'b0, cyc);
        checks++; if (cyc !== (STOP ? 22 : 169))
            $display("FAIL sa1_done_cycle got %0d exp %0d", cyc, STOP ? 22 : 169);
        else passed++;
        checks++; if (err_cnt !== (STOP ? 6'd1 : 6'd48))
            $display("FAIL sa1_err_cnt got %0d exp %0d", err_cnt, STOP ? 1 : 48);
        else passed++;
        checks++; if ({fail, fail_addr, fail_data} !== {1'b1, 4'd0, 8'h01})
            $display("FAIL sa1_diag got %b %h %h exp 1 0 01", fail, fail_addr, fail_data);
        else passed++;
    endtask

    task automatic test_err_saturation();
        int cyc;
        fault = 3;
        run(1'b0, cyc);
        checks++; if (err_cnt !== (STOP ? 6'd1 : 6'd63))
            $display("FAIL sat_err_cnt got %0d exp %0d", err_cnt, STOP ? 1 : 63);
        else passed++;
        checks++; if ({pass, fail_addr, fail_data} !== {1'b0, 4'd0, 8'hFF})
            $display("FAIL sat_diag got %b %h %h exp 0 0 ff", pass, fail_addr, fail_data);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        fault = 2;
        run(1'b1, cyc);
        checks++; if ({done, fail} !== 2'b11) $display("FAIL b2b_first_done got %b exp 11", {done, fail}); else passed++;
        @(negedge clk);
        checks++; if ({busy, done, pass, fail, err_cnt} !== {4'b1000, 6'd0})
            $display("FAIL b2b_restart_clear got %b %0d exp 1000 0", {busy, done, pass, fail}, err_cnt);
        else passed++;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk); cyc++;
        end
        checks++; if (cyc !== (STOP ? 22 : 169))
            $display("FAIL b2b_second_done got %0d exp %0d", cyc, STOP ? 22 : 169);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        int cyc;
        fault = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (59) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", busy); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, pass, fail, write_read, address, wdata, err_cnt} !== '0)
            $display("FAIL mid_async_reset got %b %h %h %0d exp all 0", {busy, done, pass, fail, write_read}, address, wdata, err_cnt);
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({busy, write_read} !== 2'b00) $display("FAIL post_reset_idle got %b exp 00", {busy, write_read}); else passed++;
        run(1'b0, cyc);
        checks++; if (cyc !== 169 || pass !== 1'b1)
            $display("FAIL post_reset_run got cycle %0d pass %b exp 169 1", cyc, pass);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_addr5_fault();
        test_stuck_bit0();
        test_err_saturation();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
